memory_access: RTL and testbench

- MEM stage of the 5-stage RV32I core. It consumes the execute-stage output bundle and performs data-memory loads and stores over a valid/ready request and response port.
- Loads: byte-lane alignment plus sign/zero extension. Stores: byte-enable generation.
- Detects misaligned accesses and presents the writeback bundle.
- Back-pressures execute with stall_out while a memory transaction is in flight.

---
 rtl/memory_access.sv | 261 ++++++++++++++++++++++++++
 tb/tb_memory_access.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access.sv
// MEM stage of the RV32I pipeline: data-memory loads/stores over a valid/ready
// request port, load lane extraction, store byte enables and misalignment traps.
module memory_access #(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned EX_W            = 4,
    parameter int unsigned EXC_LD_MISALIGN = 4,
    parameter int unsigned EXC_ST_MISALIGN = 6,
    parameter int unsigned EXC_ILLEGAL     = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pipeline_in_valid,
    input  logic [4:0]      opcode_in,
    input  logic [2:0]      funct_in,
    input  logic [XLEN-1:0] result_in,
    input  logic [XLEN-1:0] addr_in,
    input  logic [4:0]      rd_addr_in,
    input  logic            nop_instr_in,
    input  logic [EX_W-1:0] exception_in,
    input  logic            exception_in_valid,
    output logic            stall_out,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_be,
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rsp_data,
    output logic            pipeline_out_valid,
    output logic [4:0]      opcode_out,
    output logic [4:0]      rd_addr_out,
    output logic            wb_en,
    output logic [XLEN-1:0] wb_data,
    output logic [EX_W-1:0] exception_out,
    output logic            exception_out_valid
);

    localparam logic [4:0] OP_LOAD      = 5'b00000;
    localparam logic [4:0] OP_STORE     = 5'b01000;
    localparam logic [4:0] OP_ARITH     = 5'b01100;
    localparam logic [4:0] OP_IMM_ARITH = 5'b00100;
    localparam logic [4:0] OP_LUI       = 5'b01101;
    localparam logic [4:0] OP_AUIPC     = 5'b00101;
    localparam logic [4:0] OP_JAL       = 5'b11011;
    localparam logic [4:0] OP_JALR      = 5'b11001;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } state_e;

    // Access attributes needed after the request has been issued.
    typedef struct packed {
        logic       is_store;
        logic [2:0] funct;
        logic [1:0] lane;
    } acc_t;

    state_e            state_q, state_d;
    acc_t              acc_q, acc_d;
    logic              req_valid_q, req_valid_d;
    logic              we_q, we_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              pov_q, pov_d;
    logic [4:0]        opcode_out_q, opcode_out_d;
    logic [4:0]        rd_addr_out_q, rd_addr_out_d;
    logic              wb_en_q, wb_en_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic [EX_W-1:0]   exc_q, exc_d;
    logic              exc_valid_q, exc_valid_d;

    logic              is_load, is_store, is_mem, wb_op;
    logic              ld_illegal, st_illegal, ld_misalign, st_misalign;
    logic [XLEN-1:0]   rsp_shift, load_data;
    logic [XLEN-1:0]   st_wdata;
    logic [3:0]        st_be;

    // Decode of the incoming execute bundle.
    always_comb begin
        is_load     = (opcode_in == OP_LOAD);
        is_store    = (opcode_in == OP_STORE);
        is_mem      = is_load | is_store;
        wb_op       = (opcode_in == OP_ARITH) | (opcode_in == OP_IMM_ARITH) |
                      (opcode_in == OP_LUI)   | (opcode_in == OP_AUIPC)     |
                      (opcode_in == OP_JAL)   | (opcode_in == OP_JALR);
        ld_illegal  = (funct_in == 3'b011) | (funct_in == 3'b110) | (funct_in == 3'b111);
        st_illegal  = funct_in[2] | (funct_in == 3'b011);
        ld_misalign = ((funct_in[1:0] == 2'b10) && (addr_in[1:0] != 2'b00)) ||
                      ((funct_in[1:0] == 2'b01) && addr_in[0]);
        st_misalign = ((funct_in[1:0] == 2'b10) && (addr_in[1:0] != 2'b00)) ||
                      ((funct_in[1:0] == 2'b01) && addr_in[0]);
    end

    // Store lane replication and byte enables.
    always_comb begin
        st_be    = 4'hF;
        st_wdata = result_in;
        case (funct_in[1:0])
            2'b00: begin
                st_be    = 4'(4'b0001 << addr_in[1:0]);
                st_wdata = XLEN'({4{result_in[7:0]}});
            end
            2'b01: begin
                st_be    = 4'(4'b0011 << addr_in[1:0]);
                st_wdata = XLEN'({2{result_in[15:0]}});
            end
            default: begin
                st_be    = 4'hF;
                st_wdata = result_in;
            end
        endcase
    end

    // Load lane extraction; halfword accesses are already aligned so lane[0]=0.
    always_comb begin
        rsp_shift = dmem_rsp_data >> {acc_q.lane, 3'b000};
        case (acc_q.funct)
            3'b000:  load_data = {{(XLEN-8){rsp_shift[7]}}, rsp_shift[7:0]};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, rsp_shift[7:0]};
            3'b001:  load_data = {{(XLEN-16){rsp_shift[15]}}, rsp_shift[15:0]};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, rsp_shift[15:0]};
            default: load_data = dmem_rsp_data;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        req_valid_d   = req_valid_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        pov_d         = 1'b0;
        opcode_out_d  = opcode_out_q;
        rd_addr_out_d = rd_addr_out_q;
        wb_en_d       = wb_en_q;
        wb_data_d     = wb_data_q;
        exc_d         = exc_q;
        exc_valid_d   = exc_valid_q;

        case (state_q)
            IDLE: begin
                if (pipeline_in_valid) begin
                    opcode_out_d  = opcode_in;
                    rd_addr_out_d = rd_addr_in;
                    if (!is_mem || nop_instr_in || exception_in_valid) begin
                        pov_d       = 1'b1;
                        wb_data_d   = result_in;
                        exc_d       = exception_in;
                        exc_valid_d = exception_in_valid;
                        wb_en_d     = !nop_instr_in && !exception_in_valid &&
                                      (rd_addr_in != 5'd0) && wb_op;
                    end else if ((is_load && (ld_illegal || ld_misalign)) ||
                                 (is_store && (st_illegal || st_misalign))) begin
                        pov_d       = 1'b1;
                        wb_en_d     = 1'b0;
                        wb_data_d   = '0;
                        exc_valid_d = 1'b1;
                        if (is_load ? ld_illegal : st_illegal)
                            exc_d = EX_W'(EXC_ILLEGAL);
                        else if (is_load)
                            exc_d = EX_W'(EXC_LD_MISALIGN);
                        else
                            exc_d = EX_W'(EXC_ST_MISALIGN);
                    end else begin
                        acc_d.is_store = is_store;
                        acc_d.funct    = funct_in;
                        acc_d.lane     = addr_in[1:0];
                        req_valid_d    = 1'b1;
                        we_d           = is_store;
                        addr_d         = {addr_in[XLEN-1:2], 2'b00};
                        be_d           = is_store ? st_be : 4'h0;
                        wdata_d        = is_store ? st_wdata : '0;
                        state_d        = REQ;
                    end
                end
            end
            REQ: begin
                if (dmem_req_ready) begin
                    req_valid_d = 1'b0;
                    if (acc_q.is_store) begin
                        state_d     = IDLE;
                        pov_d       = 1'b1;
                        wb_en_d     = 1'b0;
                        wb_data_d   = '0;
                        exc_d       = '0;
                        exc_valid_d = 1'b0;
                    end else begin
                        state_d = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                if (dmem_rsp_valid) begin
                    state_d     = IDLE;
                    pov_d       = 1'b1;
                    wb_en_d     = (rd_addr_out_q != 5'd0);
                    wb_data_d   = load_data;
                    exc_d       = '0;
                    exc_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            req_valid_q   <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            pov_q         <= 1'b0;
            opcode_out_q  <= '0;
            rd_addr_out_q <= '0;
            wb_en_q       <= 1'b0;
            wb_data_q     <= '0;
            exc_q         <= '0;
            exc_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            req_valid_q   <= req_valid_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            be_q          <= be_d;
            pov_q         <= pov_d;
            opcode_out_q  <= opcode_out_d;
            rd_addr_out_q <= rd_addr_out_d;
            wb_en_q       <= wb_en_d;
            wb_data_q     <= wb_data_d;
            exc_q         <= exc_d;
            exc_valid_q   <= exc_valid_d;
        end
    end

    assign stall_out           = (state_q != IDLE);
    assign dmem_req_valid      = req_valid_q;
    assign dmem_we             = we_q;
    assign dmem_addr           = addr_q;
    assign dmem_wdata          = wdata_q;
    assign dmem_be             = be_q;
    assign pipeline_out_valid  = pov_q;
    assign opcode_out          = opcode_out_q;
    assign rd_addr_out         = rd_addr_out_q;
    assign wb_en               = wb_en_q;
    assign wb_data             = wb_data_q;
    assign exception_out       = exc_q;
    assign exception_out_valid = exc_valid_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access with a small valid/ready memory responder.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipeline_in_valid;
    logic [4:0]  opcode_in;
    logic [2:0]  funct_in;
    logic [31:0] result_in;
    logic [31:0] addr_in;
    logic [4:0]  rd_addr_in;
    logic        nop_instr_in;
    logic [3:0]  exception_in;
    logic        exception_in_valid;
    logic        stall_out;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_data;
    logic        pipeline_out_valid;
    logic [4:0]  opcode_out;
    logic [4:0]  rd_addr_out;
    logic        wb_en;
    logic [31:0] wb_data;
    logic [3:0]  exception_out;
    logic        exception_out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;
    localparam logic [4:0] OP_ARITH = 5'b01100;
    localparam logic [4:0] OP_BR    = 5'b11000;

    memory_access dut (
        .clk(clk), .reset(reset),
        .pipeline_in_valid(pipeline_in_valid), .opcode_in(opcode_in), .funct_in(funct_in),
        .result_in(result_in), .addr_in(addr_in), .rd_addr_in(rd_addr_in),
        .nop_instr_in(nop_instr_in), .exception_in(exception_in),
        .exception_in_valid(exception_in_valid), .stall_out(stall_out),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_data(dmem_rsp_data),
        .pipeline_out_valid(pipeline_out_valid), .opcode_out(opcode_out),
        .rd_addr_out(rd_addr_out), .wb_en(wb_en), .wb_data(wb_data),
        .exception_out(exception_out), .exception_out_valid(exception_out_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [2:0] f, input logic [31:0] res,
                         input logic [31:0] addr, input logic [4:0] rd, input logic nop,
                         input logic exv, input logic [3:0] ex);
        pipeline_in_valid  = 1'b1;
        opcode_in          = op;
        funct_in           = f;
        result_in          = res;
        addr_in            = addr;
        rd_addr_in         = rd;
        nop_instr_in       = nop;
        exception_in_valid = exv;
        exception_in       = ex;
    endtask

    // Issues one bundle and services the memory port until the stage goes idle.
    task automatic run_mem(input logic [4:0] op, input logic [2:0] f, input logic [31:0] res,
                           input logic [31:0] addr, input logic [4:0] rd,
                           input int ready_delay, input logic [31:0] rsp,
                           output int stall_cnt, output int req_cnt, output int pulse_cnt,
                           output logic r_we, output logic [31:0] r_addr,
                           output logic [3:0] r_be, output logic [31:0] r_wdata,
                           output logic hold_ok, output logic o_wb_en,
                           output logic [31:0] o_wb_data, output logic [3:0] o_exc,
                           output logic o_excv, output logic timed_out);
        logic accepted = 1'b0;
        logic done     = 1'b0;
        stall_cnt = 0; req_cnt = 0; pulse_cnt = 0; hold_ok = 1'b1;
        r_we = 1'b0; r_addr = '0; r_be = '0; r_wdata = '0;
        o_wb_en = 1'b0; o_wb_data = '0; o_exc = '0; o_excv = 1'b0;
        drive(op, f, res, addr, rd, 1'b0, 1'b0, 4'd0);
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rsp_data  = rsp;
        step();
        pipeline_in_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (stall_out) stall_cnt++;
            if (pipeline_out_valid) begin
                pulse_cnt++;
                o_wb_en = wb_en; o_wb_data = wb_data; o_exc = exception_out; o_excv = exception_out_valid;
            end
            if (dmem_req_valid) begin
                if (req_cnt == 0) begin
                    r_we = dmem_we; r_addr = dmem_addr; r_be = dmem_be; r_wdata = dmem_wdata;
                end else if (r_we !== dmem_we || r_addr !== dmem_addr || r_be !== dmem_be ||
                             r_wdata !== dmem_wdata) begin
                    hold_ok = 1'b0;
                end
                req_cnt++;
            end
            dmem_rsp_valid = accepted && !r_we;
            accepted = 1'b0;
            if (dmem_req_valid) begin
                dmem_req_ready = (req_cnt > ready_delay);
                accepted = dmem_req_ready;
            end else begin
                dmem_req_ready = 1'b0;
            end
            if (!stall_out) begin
                done = 1'b1;
                break;
            end
            step();
        end
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        timed_out = !done;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        pipeline_in_valid = 1'b0; opcode_in = '0; funct_in = '0; result_in = '0; addr_in = '0;
        rd_addr_in = '0; nop_instr_in = 1'b0; exception_in = '0; exception_in_valid = 1'b0;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_data = '0;
        step(); step();
        n_checks++; if ({stall_out, dmem_req_valid, pipeline_out_valid, wb_en, exception_out_valid} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {stall_out, dmem_req_valid, pipeline_out_valid, wb_en, exception_out_valid});
        end
        n_checks++; if ({dmem_addr, dmem_wdata, wb_data} !== 96'd0) begin
            n_fail++; $display("FAIL reset_data: addr %h wdata %h wb_data %h want 0", dmem_addr, dmem_wdata, wb_data);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_passthrough();
        logic saw_stall = 1'b0;
        drive(OP_ARITH, 3'b000, 32'h1234, 32'h0, 5'd5, 1'b0, 1'b0, 4'd0);
        saw_stall = stall_out;
        step();
        pipeline_in_valid = 1'b0;
        saw_stall = saw_stall | stall_out;
        n_checks++; if ({pipeline_out_valid, wb_en} !== 2'b11) begin
            n_fail++; $display("FAIL add_pulse: pov/wb_en %b want 11", {pipeline_out_valid, wb_en});
        end
        n_checks++; if (wb_data !== 32'h1234 || rd_addr_out !== 5'd5) begin
            n_fail++; $display("FAIL add_data: wb_data %h rd %0d want 1234 rd 5", wb_data, rd_addr_out);
        end
        step();
        saw_stall = saw_stall | stall_out;
        n_checks++; if (pipeline_out_valid !== 1'b0 || saw_stall !== 1'b0) begin
            n_fail++; $display("FAIL add_after: pov %b stall_seen %b want 0 0", pipeline_out_valid, saw_stall);
        end
        // Branch never writes rd; upstream exception is forwarded and suppresses writeback.
        drive(OP_BR, 3'b000, 32'h55, 32'h0, 5'd3, 1'b0, 1'b0, 4'd0);
        step();
        drive(OP_ARITH, 3'b000, 32'h77, 32'h0, 5'd7, 1'b0, 1'b1, 4'd3);
        n_checks++; if ({pipeline_out_valid, wb_en} !== 2'b10) begin
            n_fail++; $display("FAIL branch_wb: pov/wb_en %b want 10", {pipeline_out_valid, wb_en});
        end
        step();
        pipeline_in_valid = 1'b0;
        n_checks++; if ({pipeline_out_valid, wb_en, exception_out_valid, exception_out} !== 7'b1010011) begin
            n_fail++; $display("FAIL exc_fwd: pov/wb_en/excv/exc %b want 1010011", {pipeline_out_valid, wb_en, exception_out_valid, exception_out});
        end
        step();
    endtask

    task automatic test_loads();
        int sc, rc, pc; logic we, hold, wbe, exv, to; logic [31:0] a, wd, wbd; logic [3:0] be, ex;
        run_mem(OP_LOAD, 3'b000, 32'h0, 32'h103, 5'd9, 0, 32'h80FF_0000, sc, rc, pc, we, a, be, wd, hold, wbe, wbd, ex, exv, to);
        n_checks++; if (to || sc != 2 || rc != 1 || pc != 1) begin
            n_fail++; $display("FAIL lb_timing: stall %0d req %0d pulses %0d to %b want 2 1 1 0", sc, rc, pc, to);
        end
        n_checks++; if (wbd !== 32'hFFFF_FF80 || wbe !== 1'b1 || a !== 32'h100 || we !== 1'b0) begin
            n_fail++; $display("FAIL lb_data: wb %h wb_en %b addr %h we %b want ffffff80 1 100 0", wbd, wbe, a, we);
        end
        step();
        n_checks++; if (pipeline_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL lb_single_pulse: pov %b want 0", pipeline_out_valid);
        end
        run_mem(OP_LOAD, 3'b100, 32'h0, 32'h103, 5'd9, 0, 32'h80FF_0000, sc, rc, pc, we, a, be, wd, hold, wbe, wbd, ex, exv, to);
        n_checks++; if (wbd !== 32'h0000_0080 || to) begin
            n_fail++; $display("FAIL lbu_data: wb %h want 00000080", wbd);
        end
        run_mem(OP_LOAD, 3'b001, 32'h0, 32'h102, 5'd9, 0, 32'h80FF_0000, sc, rc, pc, we, a, be, wd, hold, wbe, wbd, ex, exv, to);
        n_checks++; if (wbd !== 32'hFFFF_80FF || to) begin
            n_fail++; $display("FAIL lh_data: wb %h want ffff80ff", wbd);
        end
        run_mem(OP_LOAD, 3'b101, 32'h0, 32'h100, 5'd9, 0, 32'h1234_8765, sc, rc, pc, we, a, be, wd, hold, wbe, wbd, ex, exv, to);
        n_checks++; if (wbd !== 32'h0000_8765 || to) begin
            n_fail++; $display("FAIL lhu_data: wb %h want 00008765", wbd);
        end
        run_mem(OP_LOAD, 3'b010, 32'h0, 32'h300, 5'd0, 0, 32'hDEAD_BEEF, sc, rc, pc, we, a, be, wd, hold, wbe, wbd, ex, exv, to);
        n_checks++; if (pc != 1 || wbe !== 1'b0 || wbd !== 32'hDEAD_BEEF || to) begin
            n_fail++; $display("FAIL lw_rd0: pulses %0d wb_en %b wb %h want 1 0 deadbeef", pc, wbe, wbd);
        end
    endtask

    task automatic test_stores();
        int sc, rc, pc; logic we, hold, wbe, exv, to; logic [31:0] a, wd, wbd; logic [3:0] be, ex;
        run_mem(OP_STORE, 3'b001, 32'h0000_ABCD, 32'h202, 5'd0, 3, 32'h0, sc, rc, pc, we, a, be, wd, hold, wbe, wbd, ex, exv, to);
        n_checks++; if (to || rc != 4 || !hold || pc != 1 || wbe !== 1'b0) begin
            n_fail++; $display("FAIL sh_hold: req %0d hold %b pulses %0d wb_en %b want 4 1 1 0", rc, hold, pc, wbe);
        end
        n_checks++; if (a !== 32'h200 || be !== 4'b1100 || wd !== 32'hABCD_ABCD || we !== 1'b1) begin
            n_fail++; $display("FAIL sh_req: addr %h be %b wdata %h we %b want 200 1100 abcdabcd 1", a, be, wd, we);
        end
        run_mem(OP_STORE, 3'b000, 32'h0000_005A, 32'h201, 5'd0, 0, 32'h0, sc, rc, pc, we, a, be, wd, hold, wbe, wbd, ex, exv, to);
        n_checks++; if (sc != 1 || be !== 4'b0010 || wd !== 32'h5A5A_5A5A || to) begin
            n_fail++; $display("FAIL sb_req: stall %0d be %b wdata %h want 1 0010 5a5a5a5a", sc, be, wd);
        end
        run_mem(OP_STORE, 3'b010, 32'h1122_3344, 32'h204, 5'd0, 0, 32'h0, sc, rc, pc, we, a, be, wd, hold, wbe, wbd, ex, exv, to);
        n_checks++; if (be !== 4'hF || wd !== 32'h1122_3344 || a !== 32'h204 || to) begin
            n_fail++; $display("FAIL sw_req: be %h wdata %h addr %h want f 11223344 204", be, wd, a);
        end
    endtask

    task automatic test_exceptions();
        int sc, rc, pc; logic we, hold, wbe, exv, to; logic [31:0] a, wd, wbd; logic [3:0] be, ex;
        run_mem(OP_LOAD, 3'b010, 32'h0, 32'h101, 5'd4, 0, 32'h0, sc, rc, pc, we, a, be, wd, hold, wbe, wbd, ex, exv, to);
        n_checks++; if (rc != 0 || sc != 0 || pc != 1 || exv !== 1'b1 || ex !== 4'd4 || wbe !== 1'b0) begin
            n_fail++; $display("FAIL lw_misalign: req %0d stall %0d pulses %0d excv %b exc %0d wb_en %b want 0 0 1 1 4 0", rc, sc, pc, exv, ex, wbe);
        end
        run_mem(OP_STORE, 3'b010, 32'h0, 32'h106, 5'd0, 0, 32'h0, sc, rc, pc, we, a, be, wd, hold, wbe, wbd, ex, exv, to);
        n_checks++; if (rc != 0 || exv !== 1'b1 || ex !== 4'd6) begin
            n_fail++; $display("FAIL sw_misalign: req %0d excv %b exc %0d want 0 1 6", rc, exv, ex);
        end
        run_mem(OP_LOAD, 3'b001, 32'h0, 32'h103, 5'd4, 0, 32'h0, sc, rc, pc, we, a, be, wd, hold, wbe, wbd, ex, exv, to);
        n_checks++; if (rc != 0 || ex !== 4'd4 || exv !== 1'b1) begin
            n_fail++; $display("FAIL lh_misalign: req %0d excv %b exc %0d want 0 1 4", rc, exv, ex);
        end
        run_mem(OP_LOAD, 3'b011, 32'h0, 32'h100, 5'd4, 0, 32'h0, sc, rc, pc, we, a, be, wd, hold, wbe, wbd, ex, exv, to);
        n_checks++; if (rc != 0 || ex !== 4'd2 || exv !== 1'b1) begin
            n_fail++; $display("FAIL ld_illegal: req %0d excv %b exc %0d want 0 1 2", rc, exv, ex);
        end
        run_mem(OP_STORE, 3'b100, 32'h0, 32'h100, 5'd0, 0, 32'h0, sc, rc, pc, we, a, be, wd, hold, wbe, wbd, ex, exv, to);
        n_checks++; if (rc != 0 || ex !== 4'd2 || exv !== 1'b1) begin
            n_fail++; $display("FAIL st_illegal: req %0d excv %b exc %0d want 0 1 2", rc, exv, ex);
        end
    endtask

    task automatic test_reset_mid();
        drive(OP_LOAD, 3'b010, 32'h0, 32'h400, 5'd8, 1'b0, 1'b0, 4'd0);
        dmem_req_ready = 1'b1;
        step();
        pipeline_in_valid = 1'b0;
        step();
        dmem_req_ready = 1'b0;
        n_checks++; if (stall_out !== 1'b1 || dmem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_wait_state: stall %b req %b want 1 0", stall_out, dmem_req_valid);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++; if ({stall_out, dmem_req_valid, pipeline_out_valid, wb_en, dmem_we, dmem_be} !== 9'b0 || dmem_addr !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset_clear: stall %b req %b pov %b addr %h", stall_out, dmem_req_valid, pipeline_out_valid, dmem_addr);
        end
        #1 reset = 1'b1;
        dmem_rsp_valid = 1'b1;
        dmem_rsp_data  = 32'hCAFE_F00D;
        step();
        dmem_rsp_valid = 1'b0;
        n_checks++; if (pipeline_out_valid !== 1'b0 || stall_out !== 1'b0 || wb_data !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset_rsp: pov %b stall %b wb %h want 0 0 0", pipeline_out_valid, stall_out, wb_data);
        end
        step();
        n_checks++; if (pipeline_out_valid !== 1'b0 || stall_out !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_after: pov %b stall %b want 0 0", pipeline_out_valid, stall_out);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_loads();
        test_stores();
        test_exceptions();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
